// File: rtl/pwm_pkg.sv
// Shared PWM definitions: default duty width, ramp FSM encoding and the
// saturating step helpers used by both the ramp block and the PWM peripheral.
package pwm_pkg;

  localparam int DUTY_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    BYPASS = 2'd2
  } ramp_state_e;

  // cur + step clamped to lim; the sum carries an extra bit so it cannot wrap
  function automatic logic [31:0] sat_add(input logic [31:0] cur,
                                          input logic [31:0] step,
                                          input logic [31:0] lim);
    logic [32:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (sum > {1'b0, lim}) return lim;
    return sum[31:0];
  endfunction

  // cur - step clamped to lim; the gap is checked first so nothing underflows
  function automatic logic [31:0] sat_sub(input logic [31:0] cur,
                                          input logic [31:0] step,
                                          input logic [31:0] lim);
    if (cur <= lim) return lim;
    if ((cur - lim) <= step) return lim;
    return cur - step;
  endfunction

endpackage

// File: rtl/pwm_tick_div.sv
// Divides PWM period strobes down to ramp ticks: one tick every STEP_DIV strobes.
// The clear input holds the prescaler at zero so a new ramp always starts a
// full division interval.
module pwm_tick_div #(
  parameter int STEP_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic strobe,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] presc_q, presc_d;

  // Prescaler next value and tick on the strobe that completes an interval
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (clr) begin
      presc_d = '0;
    end else if (strobe) begin
      if (presc_q == LAST) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + CW'(1);
      end
    end
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slew-rate limiter between the SPI duty register and the PWM peripheral.
// Applied duty moves toward the programmed target in STEP increments, one step
// per STEP_DIV PWM periods, and only ever changes on a period strobe.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | duty_out equals target_q, nothing pending
//   RAMP   | stepping toward target_q on each divided tick
//   BYPASS | waiting for the next period strobe to load target_q directly
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int DUTY_W   = DUTY_W_DEF,
  parameter int STEP     = 16,
  parameter int STEP_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              ramp_en,
  input  logic              period_strobe,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done
);

  if (STEP < 1) begin : g_bad_step
    $error("pwm_duty_ramp: STEP must be >= 1");
  end
  if (STEP_DIV < 1) begin : g_bad_div
    $error("pwm_duty_ramp: STEP_DIV must be >= 1");
  end

  ramp_state_e       state_q, state_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DUTY_W-1:0] step_val;
  logic              tick;

  pwm_tick_div #(.STEP_DIV(STEP_DIV)) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != RAMP),
    .strobe (period_strobe),
    .tick   (tick)
  );

  // Next duty one step toward the target; direction re-evaluated every cycle
  always_comb begin
    if (target_q > duty_q)
      step_val = DUTY_W'(sat_add(32'(duty_q), 32'(STEP), 32'(target_q)));
    else
      step_val = DUTY_W'(sat_sub(32'(duty_q), 32'(STEP), 32'(target_q)));
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      duty_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      duty_q   <= duty_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state decision, always against the registered target
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (target_q != duty_q) state_d = ramp_en ? RAMP : BYPASS;
      end
      RAMP: begin
        if (target_q == duty_q)             state_d = IDLE;
        else if (!ramp_en)                  state_d = BYPASS;
        else if (tick && step_val == target_q) state_d = IDLE;
      end
      BYPASS: begin
        if (period_strobe) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: duty updates only on strobe-qualified events, done on return to IDLE
  always_comb begin
    target_d = target_duty;
    duty_d   = duty_q;
    if (state_q == RAMP && ramp_en && target_q != duty_q && tick)
      duty_d = step_val;
    else if (state_q == BYPASS && period_strobe)
      duty_d = target_q;
    busy_d = (state_d != IDLE);
    done_d = (state_q != IDLE) && (state_d == IDLE);
  end

  assign duty_out = duty_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: STEP=16, STEP_DIV=2, strobe every 256 clk.
module tb_pwm_duty_ramp;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] target_duty;
  logic       ramp_en;
  logic       period_strobe;
  logic [7:0] duty_out;
  logic       busy;
  logic       done;

  int passed = 0;
  int total  = 0;

  int   scnt = 0;
  int   strobe_num = 0;
  int   glitch_cnt = 0;
  int   done_cnt = 0;
  logic [7:0] prev_duty = 8'h00;
  logic [7:0] seq[$];
  int         seq_strb[$];

  always #5 clk = ~clk;

  pwm_duty_ramp #(.DUTY_W(8), .STEP(16), .STEP_DIV(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .target_duty   (target_duty),
    .ramp_en       (ramp_en),
    .period_strobe (period_strobe),
    .duty_out      (duty_out),
    .busy          (busy),
    .done          (done)
  );

  // period strobe: one clk wide, every 256 clk
  initial begin
    period_strobe = 1'b0;
    forever begin
      @(negedge clk);
      scnt++;
      if (scnt == 256) begin
        scnt = 0;
        period_strobe = 1'b1;
        strobe_num++;
      end else begin
        period_strobe = 1'b0;
      end
    end
  end

  // log every duty change, flag changes outside strobe cycles, count done pulses
  always @(posedge clk) begin
    logic s, r;
    s = period_strobe;
    r = rst;
    #1;
    if (duty_out !== prev_duty) begin
      if (!s && !r) glitch_cnt++;
      seq.push_back(duty_out);
      seq_strb.push_back(strobe_num);
      prev_duty = duty_out;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic clear_log();
    seq.delete();
    seq_strb.delete();
    done_cnt = 0;
  endtask

  task automatic wait_seq(input int n, input string name);
    int cyc = 0;
    while (seq.size() < n && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    if (seq.size() < n) begin
      total++;
      $display("FAIL %s_timeout: got %0d duty changes, expected %0d", name, seq.size(), n);
    end
  endtask

  task automatic go_bypass(input logic [7:0] val);
    clear_log();
    ramp_en = 1'b0;
    target_duty = val;
    wait_seq(1, "bypass_setup");
    repeat (5) @(negedge clk);
    ramp_en = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ramp_en = 1'b1;
    target_duty = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (600) @(negedge clk);
    total++; if (duty_out !== 8'h00) $display("FAIL reset_duty: got %h expected 00", duty_out); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done_cnt !== 0) $display("FAIL reset_done: got %0d pulses expected 0", done_cnt); else passed++;
  endtask

  task automatic test_ramp_up();
    logic [7:0] exp_v [4];
    logic [7:0] got;
    exp_v = '{8'h10, 8'h20, 8'h30, 8'h40};
    clear_log();
    target_duty = 8'h40;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL up_latency_busy1: got %b expected 0", busy); else passed++;
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) $display("FAIL up_latency_busy2: got %b expected 1", busy); else passed++;
    wait_seq(2, "up_mid");
    total++; if (busy !== 1'b1) $display("FAIL up_busy_mid: got %b expected 1", busy); else passed++;
    wait_seq(4, "up");
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      got = (i < seq.size()) ? seq[i] : 8'hxx;
      total++; if (got !== exp_v[i]) $display("FAIL up_seq[%0d]: got %h expected %h", i, got, exp_v[i]); else passed++;
    end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (i >= seq_strb.size() || seq_strb[i] - seq_strb[i-1] !== 2)
        $display("FAIL up_strobe_gap[%0d]: got %0d expected 2", i,
                 (i < seq_strb.size()) ? seq_strb[i] - seq_strb[i-1] : -1);
      else passed++;
    end
    total++; if (seq.size() !== 4) $display("FAIL up_len: got %0d expected 4", seq.size()); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL up_busy_end: got %b expected 0", busy); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL up_done: got %0d expected 1", done_cnt); else passed++;
  endtask

  task automatic test_ramp_down();
    logic [7:0] exp_v [4];
    logic [7:0] got;
    exp_v = '{8'h30, 8'h20, 8'h10, 8'h05};
    clear_log();
    target_duty = 8'h05;
    wait_seq(4, "down");
    repeat (600) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      got = (i < seq.size()) ? seq[i] : 8'hxx;
      total++; if (got !== exp_v[i]) $display("FAIL down_seq[%0d]: got %h expected %h", i, got, exp_v[i]); else passed++;
    end
    total++; if (seq.size() !== 4) $display("FAIL down_len: got %0d expected 4", seq.size()); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL down_done: got %0d expected 1", done_cnt); else passed++;
  endtask

  task automatic test_top_sat();
    go_bypass(8'hF0);
    total++; if (duty_out !== 8'hF0) $display("FAIL bypass_load: got %h expected f0", duty_out); else passed++;
    target_duty = 8'hF8;
    wait_seq(1, "top");
    repeat (600) @(negedge clk);
    total++; if (seq.size() !== 1 || seq[0] !== 8'hF8)
      $display("FAIL top_sat: got %h (%0d changes) expected f8 (1 change)",
               (seq.size() > 0) ? seq[0] : 8'hxx, seq.size());
    else passed++;
    total++; if (done_cnt !== 1) $display("FAIL top_done: got %0d expected 1", done_cnt); else passed++;
  endtask

  task automatic test_reverse();
    logic [7:0] exp_v [5];
    logic [7:0] got;
    exp_v = '{8'h10, 8'h20, 8'h30, 8'h20, 8'h10};
    go_bypass(8'h00);
    target_duty = 8'h80;
    wait_seq(3, "rev_up");
    target_duty = 8'h10;
    wait_seq(5, "rev");
    repeat (600) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      got = (i < seq.size()) ? seq[i] : 8'hxx;
      total++; if (got !== exp_v[i]) $display("FAIL rev_seq[%0d]: got %h expected %h", i, got, exp_v[i]); else passed++;
    end
    total++; if (seq.size() !== 5) $display("FAIL rev_len: got %0d expected 5", seq.size()); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL rev_done: got %0d expected 1", done_cnt); else passed++;
  endtask

  task automatic test_ramp_to_bypass();
    logic [7:0] got;
    go_bypass(8'h00);
    target_duty = 8'h80;
    wait_seq(3, "r2b_up");
    ramp_en = 1'b0;
    wait_seq(4, "r2b");
    repeat (10) @(negedge clk);
    got = (seq.size() > 3) ? seq[3] : 8'hxx;
    total++; if (got !== 8'h80) $display("FAIL r2b_value: got %h expected 80", got); else passed++;
    total++;
    if (seq_strb.size() < 4 || seq_strb[3] - seq_strb[2] !== 1)
      $display("FAIL r2b_strobe_gap: got %0d expected 1",
               (seq_strb.size() > 3) ? seq_strb[3] - seq_strb[2] : -1);
    else passed++;
    total++; if (done_cnt !== 1) $display("FAIL r2b_done: got %0d expected 1", done_cnt); else passed++;
    ramp_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    go_bypass(8'h00);
    target_duty = 8'h80;
    wait_seq(3, "rst_up");
    rst = 1'b1;
    done_cnt = 0;
    @(posedge clk); #1;
    total++; if (duty_out !== 8'h00) $display("FAIL rst_mid_duty: got %h expected 00", duty_out); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else passed++;
    @(negedge clk);
    target_duty = 8'h20;
    repeat (2) @(negedge clk);
    total++; if (done_cnt !== 0) $display("FAIL rst_mid_done: got %0d expected 0", done_cnt); else passed++;
    clear_log();
    rst = 1'b0;
    wait_seq(2, "rst_restart");
    repeat (10) @(negedge clk);
    got = (seq.size() > 0) ? seq[0] : 8'hxx;
    total++; if (got !== 8'h10) $display("FAIL restart_seq[0]: got %h expected 10", got); else passed++;
    got = (seq.size() > 1) ? seq[1] : 8'hxx;
    total++; if (got !== 8'h20) $display("FAIL restart_seq[1]: got %h expected 20", got); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL restart_done: got %0d expected 1", done_cnt); else passed++;
  endtask

  task automatic test_no_glitch();
    total++; if (glitch_cnt !== 0) $display("FAIL glitch: got %0d off-strobe duty changes expected 0", glitch_cnt); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    ramp_en = 1'b1;
    target_duty = 8'h00;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_top_sat();
    test_reverse();
    test_ramp_to_bypass();
    test_reset_mid();
    test_no_glitch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
